// File: rtl/ecc_pkg.sv
// ecc_pkg: curve constants, error codes and FSM encoding shared by the ECC pipeline stages
//   Config macro: ECC_CHECK_A_TERM_EN adds the MUL_AX state (generic a*Px term)
package ecc_pkg;
   localparam int DATA_WIDTH = 256;
   localparam logic [255:0] P_MOD   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [255:0] N_ORD   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
   localparam logic [255:0] CURVE_A = 256'd0;
   localparam logic [255:0] CURVE_B = 256'd7;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_PX_RANGE     = 3'd1,
      ERR_PY_RANGE     = 3'd2,
      ERR_K_ZERO       = 3'd3,
      ERR_K_RANGE      = 3'd4,
      ERR_NOT_ON_CURVE = 3'd5
   } err_code_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RANGE,
      ST_MUL_YY,
      ST_MUL_XX,
      ST_MUL_XXX,
`ifdef ECC_CHECK_A_TERM_EN
      ST_MUL_AX,
`endif
      ST_SUM,
      ST_CMP,
      ST_DISPATCH,
      ST_WAIT_DP,
      ST_ERR
   } state_e;
endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: MSB-first interleaved modular multiplier, r_o = a_i*b_i mod P_MOD
//   clk, rst_n (async, active-low); start_i latches a_i/b_i (both < P_MOD), restarts if running;
//   done_o pulses exactly W+1 cycles after start_i; r_o holds the result until the next start
module mod_mul_serial #(
   parameter int W = ecc_pkg::DATA_WIDTH,
   parameter logic [W-1:0] P_MOD = ecc_pkg::P_MOD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         done_o,
   output logic [W-1:0] r_o
);
   localparam int CW = $clog2(W);
   logic [W-1:0] acc_q, a_q, b_q, dbl_d, acc_d;
   logic [CW-1:0] cnt_q;
   logic run_q, done_q;
   // operands are < p, so one conditional subtract of p fully reduces the W+1 bit sum
   function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] t, u;
      t = {1'b0, x} + {1'b0, y};
      u = t - {1'b0, P_MOD};
      return (t >= {1'b0, P_MOD}) ? u[W-1:0] : t[W-1:0];
   endfunction
   assign dbl_d = add_mod(acc_q, acc_q);
   assign acc_d = b_q[W-1] ? add_mod(dbl_d, a_q) : dbl_d;
   assign done_o = done_q;
   assign r_o = acc_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         a_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            acc_q <= '0;
            a_q <= a_i;
            b_q <= b_i;
            cnt_q <= CW'(W - 1);
            run_q <= 1'b1;
         end else if (run_q) begin
            acc_q <= acc_d;
            b_q <= {b_q[W-2:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
               run_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/ecc_point_check.sv
// ecc_point_check: range- and curve-checks a (Px, Py, k) job, then dispatches it to the scalar-mult core
//   clk, rst_n (async, active-low); in_valid/in_ready job handshake with Px, Py, k sampled on accept;
//   out_valid 1-cycle dispatch pulse with out_Px/out_Py/out_k held until dp_done; err_valid/err_code
//   report rejected jobs; busy = !in_ready. Macro ECC_CHECK_A_TERM_EN enables the CURVE_A*Px term.
module ecc_point_check #(
   parameter int DATA_WIDTH = ecc_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] P_MOD = ecc_pkg::P_MOD,
   parameter logic [DATA_WIDTH-1:0] N_ORD = ecc_pkg::N_ORD,
`ifdef ECC_CHECK_A_TERM_EN
   parameter logic [DATA_WIDTH-1:0] CURVE_A = ecc_pkg::CURVE_A,
`endif
   parameter logic [DATA_WIDTH-1:0] CURVE_B = ecc_pkg::CURVE_B
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] Px,
   input  logic [DATA_WIDTH-1:0] Py,
   input  logic [DATA_WIDTH-1:0] k,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_Px,
   output logic [DATA_WIDTH-1:0] out_Py,
   output logic [DATA_WIDTH-1:0] out_k,
   input  logic                  dp_done,
   output logic                  err_valid,
   output logic [2:0]            err_code,
   output logic                  busy
);
   import ecc_pkg::*;
   localparam int W = DATA_WIDTH;
   state_e state_q;
   err_code_e err_code_q, range_err;
   logic [W-1:0] px_q, py_q, k_q, yy_q, xx_q, xxx_q, rhs_q, rhs_d;
   logic [W-1:0] mul_a, mul_b, mul_r;
   logic out_valid_q, err_valid_q, mul_start_q, mul_done;
`ifdef ECC_CHECK_A_TERM_EN
   logic [W-1:0] ax_q;
`endif
   function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] t, u;
      t = {1'b0, x} + {1'b0, y};
      u = t - {1'b0, P_MOD};
      return (t >= {1'b0, P_MOD}) ? u[W-1:0] : t[W-1:0];
   endfunction
   // first failing check wins: Px, Py, k==0, k>=n
   assign range_err = (px_q >= P_MOD) ? ERR_PX_RANGE :
                      (py_q >= P_MOD) ? ERR_PY_RANGE :
                      (k_q == '0)     ? ERR_K_ZERO   :
                      (k_q >= N_ORD)  ? ERR_K_RANGE  : ERR_NONE;
`ifdef ECC_CHECK_A_TERM_EN
   assign rhs_d = add_mod(add_mod(xxx_q, CURVE_B), ax_q);
`else
   assign rhs_d = add_mod(xxx_q, CURVE_B);
`endif
   // the multiplier latches its operands on start, so the mux only has to be right in the start cycle
   assign mul_a = (state_q == ST_MUL_YY)  ? py_q :
                  (state_q == ST_MUL_XXX) ? xx_q :
`ifdef ECC_CHECK_A_TERM_EN
                  (state_q == ST_MUL_AX)  ? CURVE_A :
`endif
                  px_q;
   assign mul_b = (state_q == ST_MUL_YY) ? py_q : px_q;
   mod_mul_serial #(.W(W), .P_MOD(P_MOD)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (mul_start_q),
      .a_i     (mul_a),
      .b_i     (mul_b),
      .done_o  (mul_done),
      .r_o     (mul_r)
   );
   assign in_ready = (state_q == ST_IDLE);
   assign busy = !in_ready;
   assign out_valid = out_valid_q;
   assign err_valid = err_valid_q;
   assign err_code = err_code_q;
   assign out_Px = px_q;
   assign out_Py = py_q;
   assign out_k = k_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         px_q <= '0;
         py_q <= '0;
         k_q <= '0;
         yy_q <= '0;
         xx_q <= '0;
         xxx_q <= '0;
         rhs_q <= '0;
`ifdef ECC_CHECK_A_TERM_EN
         ax_q <= '0;
`endif
         err_code_q <= ERR_NONE;
         out_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (in_valid) begin
               px_q <= Px;
               py_q <= Py;
               k_q <= k;
               err_code_q <= ERR_NONE;
               state_q <= ST_LOAD;
            end
            ST_LOAD: state_q <= ST_RANGE;
            ST_RANGE: if (range_err != ERR_NONE) begin
               err_code_q <= range_err;
               err_valid_q <= 1'b1;
               state_q <= ST_ERR;
            end else begin
               mul_start_q <= 1'b1;
               state_q <= ST_MUL_YY;
            end
            ST_MUL_YY: if (mul_done) begin
               yy_q <= mul_r;
               mul_start_q <= 1'b1;
               state_q <= ST_MUL_XX;
            end
            ST_MUL_XX: if (mul_done) begin
               xx_q <= mul_r;
               mul_start_q <= 1'b1;
               state_q <= ST_MUL_XXX;
            end
            ST_MUL_XXX: if (mul_done) begin
               xxx_q <= mul_r;
`ifdef ECC_CHECK_A_TERM_EN
               mul_start_q <= 1'b1;
               state_q <= ST_MUL_AX;
`else
               state_q <= ST_SUM;
`endif
            end
`ifdef ECC_CHECK_A_TERM_EN
            ST_MUL_AX: if (mul_done) begin
               ax_q <= mul_r;
               state_q <= ST_SUM;
            end
`endif
            ST_SUM: begin
               rhs_q <= rhs_d;
               state_q <= ST_CMP;
            end
            ST_CMP: if (rhs_q == yy_q) begin
               out_valid_q <= 1'b1;
               state_q <= ST_DISPATCH;
            end else begin
               err_code_q <= ERR_NOT_ON_CURVE;
               err_valid_q <= 1'b1;
               state_q <= ST_ERR;
            end
            ST_DISPATCH: state_q <= dp_done ? ST_IDLE : ST_WAIT_DP;
            ST_WAIT_DP: if (dp_done) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_point_check.sv
// tb_ecc_point_check: scoreboard bench for ecc_point_check with directed curve vectors
module tb_ecc_point_check;
   localparam int W = 256;
`ifdef ECC_CHECK_A_TERM_EN
   localparam logic [W-1:0] TP = 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
   localparam logic [W-1:0] TN = 256'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF_BCE6FAAD_A7179E84_F3B9CAC2_FC632551;
   localparam logic [W-1:0] TA = 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFC;
   localparam logic [W-1:0] TB = 256'h5AC635D8_AA3A93E7_B3EBBD55_769886BC_651D06B0_CC53B0F6_3BCE3C3E_27D2604B;
   localparam logic [W-1:0] GX = 256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296;
   localparam logic [W-1:0] GY = 256'h4FE342E2_FE1A7F9B_8EE7EB4A_7C0F9E16_2BCE3357_6B315ECE_CBB64068_37BF51F5;
   localparam int LAT = 1037;
`else
   localparam logic [W-1:0] TP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [W-1:0] TN = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
   localparam logic [W-1:0] TB = 256'd7;
   localparam logic [W-1:0] GX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
   localparam logic [W-1:0] GY = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
   localparam int LAT = 779;
`endif
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, dp_done = 1'b0;
   logic [W-1:0] Px = '0, Py = '0, k = '0;
   logic in_ready, out_valid, err_valid, busy;
   logic [W-1:0] out_Px, out_Py, out_k;
   logic [2:0] err_code;
   int total = 0, bad = 0, cyc = 0, dp_delay = 10, ev_cnt = 0;
   typedef struct {
      bit disp;
      logic [2:0] code;
      logic [W-1:0] px, py, kk;
      int t0, lat;
   } exp_t;
   exp_t sb[$];

   ecc_point_check #(
      .DATA_WIDTH(W), .P_MOD(TP), .N_ORD(TN),
`ifdef ECC_CHECK_A_TERM_EN
      .CURVE_A(TA),
`endif
      .CURVE_B(TB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Px(Px), .Py(Py), .k(k), .out_valid(out_valid), .out_Px(out_Px), .out_Py(out_Py),
      .out_k(out_k), .dp_done(dp_done), .err_valid(err_valid), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] px, input logic [W-1:0] py, input logic [W-1:0] kk,
                       input bit disp, input logic [2:0] code, input int lat, input bit push);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      Px = px;
      Py = py;
      k = kk;
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
      end else if (push) sb.push_back('{disp, code, px, py, kk, cyc, lat});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_ready && sb.size() == 0) && n < 3000);
      if (n >= 3000) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: in_ready=%0b pending=%0d, expected idle", in_ready, sb.size());
      end
   endtask

   // monitor: every out_valid/err_valid pulse is matched against the oldest expected job
   initial forever begin
      @(negedge clk);
      if (out_valid || err_valid) begin
         ev_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: out_valid=%0b err_valid=%0b, expected no pulse", out_valid, err_valid);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chki("out_valid", int'(out_valid), int'(e.disp));
            chki("err_valid", int'(err_valid), int'(!e.disp));
            chki("latency", cyc - e.t0, e.lat);
            if (e.disp) begin
               chk("out_Px", out_Px, e.px);
               chk("out_Py", out_Py, e.py);
               chk("out_k", out_k, e.kk);
            end else chki("err_code", int'(err_code), int'(e.code));
         end
      end
   end

   // scalar-mult core stand-in: answers each dispatch with dp_done after dp_delay cycles
   initial forever begin
      @(negedge clk);
      if (out_valid) begin
         repeat (dp_delay) @(negedge clk);
         chki("busy_before_done", int'(busy), 1);
         dp_done = 1'b1;
         @(negedge clk);
         dp_done = 1'b0;
         chki("ready_after_done", int'(in_ready), 1);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n_ev;
      repeat (3) @(negedge clk);
      chki("rst_in_ready", int'(in_ready), 1);
      chki("rst_busy", int'(busy), 0);
      chki("rst_out_valid", int'(out_valid), 0);
      chki("rst_err_valid", int'(err_valid), 0);
      chki("rst_err_code", int'(err_code), 0);
      chk("rst_out_Px", out_Px, '0);
      rst_n = 1'b1;
      // valid generator, k=1
      dp_delay = 10;
      send(GX, GY, 256'd1, 1'b1, 3'd0, LAT, 1'b1);
      wait_idle();
      // off-curve point
      send(GX, GY ^ 256'd1, 256'd5, 1'b0, 3'd5, LAT, 1'b1);
      wait_idle();
      // range checks and priority
      send(GX, GY, 256'd0, 1'b0, 3'd3, 3, 1'b1);
      send(GX, GY, TN, 1'b0, 3'd4, 3, 1'b1);
      send(TP, TP, 256'd1, 1'b0, 3'd1, 3, 1'b1);
      send(GX, TP, 256'd1, 1'b0, 3'd2, 3, 1'b1);
      send(TP, GY, 256'd0, 1'b0, 3'd1, 3, 1'b1);
      // largest legal k, dp_done in the dispatch cycle
      dp_delay = 0;
      send(GX, GY, TN - 256'd1, 1'b1, 3'd0, LAT, 1'b1);
      wait_idle();
      // new request held during WAIT_DP
      dp_delay = 40;
      send(GX, GY, 256'd2, 1'b1, 3'd0, LAT, 1'b1);
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL dispatch_timeout: pending=%0d, expected 0", sb.size());
      end
      in_valid = 1'b1;
      Px = 256'd1;
      Py = 256'd2;
      k = 256'd3;
      repeat (20) begin
         @(negedge clk);
         chki("hold_in_ready", int'(in_ready), 0);
         chk("hold_out_Px", out_Px, GX);
         chk("hold_out_k", out_k, 256'd2);
      end
      send(256'd1, 256'd2, 256'd3, 1'b0, 3'd5, LAT, 1'b1);
      wait_idle();
      // reset in the middle of MUL_XX drops the job silently
      dp_delay = 10;
      send(GX, GY, 256'd1, 1'b1, 3'd0, LAT, 1'b0);
      repeat (350) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chki("mid_rst_in_ready", int'(in_ready), 1);
      chki("mid_rst_busy", int'(busy), 0);
      chki("mid_rst_out_valid", int'(out_valid), 0);
      chki("mid_rst_err_code", int'(err_code), 0);
      chk("mid_rst_out_Px", out_Px, '0);
      chk("mid_rst_out_k", out_k, '0);
      n_ev = ev_cnt;
      rst_n = 1'b1;
      repeat (900) @(negedge clk);
      chki("no_pulse_after_rst", ev_cnt, n_ev);
      send(GX, GY, 256'd1, 1'b1, 3'd0, LAT, 1'b1);
      wait_idle();
      chki("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
